// File: rtl/b1_loc_gen_pkg.sv
// Shared constants, types and helpers for the B1I local replica generator.
// Combinational only; no latency or backpressure involved.
package b1_pkg;

    localparam int          PHASE_W     = 32;
    localparam int          B1_CODE_LEN = 2046;
    // Bit i-1 holds LFSR stage i; stage 11 is the output stage.
    localparam logic [10:0] B1_G_INIT   = 11'b01010101010;
    localparam logic [10:0] G1_FB_MASK  = 11'b11111000001;  // stages 1,7,8,9,10,11
    localparam logic [10:0] G2_FB_MASK  = 11'b10110011111;  // stages 1,2,3,4,5,8,9,11

    typedef struct packed {
        logic        early;
        logic        epoch;
        logic [10:0] chip;
    } dlyStage_t;

    // Out-of-range tap values fall back to stage 1.
    function automatic logic g2Tap(input logic [10:0] g, input logic [3:0] t);
        logic r;
        r = g[0];
        for (int i = 1; i <= 11; i++) begin
            if (t == 4'(i)) r = g[i-1];
        end
        return r;
    endfunction

    // G2 phase-selector taps for B1I PRN 1..37; anything else maps to PRN1.
    function automatic logic [7:0] prn_taps(input logic [5:0] prn);
        logic [7:0] r;
        case (prn)
            6'd1:  r = {4'd1, 4'd3};   6'd2:  r = {4'd1, 4'd4};   6'd3:  r = {4'd1, 4'd5};
            6'd4:  r = {4'd1, 4'd6};   6'd5:  r = {4'd1, 4'd8};   6'd6:  r = {4'd1, 4'd9};
            6'd7:  r = {4'd1, 4'd10};  6'd8:  r = {4'd1, 4'd11};  6'd9:  r = {4'd2, 4'd7};
            6'd10: r = {4'd3, 4'd4};   6'd11: r = {4'd3, 4'd5};   6'd12: r = {4'd3, 4'd6};
            6'd13: r = {4'd3, 4'd8};   6'd14: r = {4'd3, 4'd9};   6'd15: r = {4'd3, 4'd10};
            6'd16: r = {4'd3, 4'd11};  6'd17: r = {4'd4, 4'd5};   6'd18: r = {4'd4, 4'd6};
            6'd19: r = {4'd4, 4'd8};   6'd20: r = {4'd4, 4'd9};   6'd21: r = {4'd4, 4'd10};
            6'd22: r = {4'd4, 4'd11};  6'd23: r = {4'd5, 4'd6};   6'd24: r = {4'd5, 4'd8};
            6'd25: r = {4'd5, 4'd9};   6'd26: r = {4'd5, 4'd10};  6'd27: r = {4'd5, 4'd11};
            6'd28: r = {4'd6, 4'd8};   6'd29: r = {4'd6, 4'd9};   6'd30: r = {4'd6, 4'd10};
            6'd31: r = {4'd6, 4'd11};  6'd32: r = {4'd8, 4'd9};   6'd33: r = {4'd8, 4'd10};
            6'd34: r = {4'd8, 4'd11};  6'd35: r = {4'd9, 4'd10};  6'd36: r = {4'd9, 4'd11};
            6'd37: r = {4'd10, 4'd11};
            default: r = {4'd1, 4'd3};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/b1_loc_gen_if.sv
// Control inputs and replica outputs of the B1 local replica generator.
// master = tracking-loop side, slave = generator side.
interface b1_loc_gen_if #(parameter int PHASE_W = 32);
    logic               rx_en;
    logic               rx_load;
    logic [3:0]         rx_g2_tap1;
    logic [3:0]         rx_g2_tap2;
    logic [PHASE_W-1:0] rx_prn_fcw;
    logic               tx_loc_bocE;
    logic               tx_loc_bocP;
    logic               tx_loc_bocL;
    logic               tx_prn_sop;
    logic [10:0]        tx_chip_idx;

    modport master (output rx_en, rx_load, rx_g2_tap1, rx_g2_tap2, rx_prn_fcw,
                    input  tx_loc_bocE, tx_loc_bocP, tx_loc_bocL, tx_prn_sop, tx_chip_idx);
    modport slave  (input  rx_en, rx_load, rx_g2_tap1, rx_g2_tap2, rx_prn_fcw,
                    output tx_loc_bocE, tx_loc_bocP, tx_loc_bocL, tx_prn_sop, tx_chip_idx);
endinterface

// File: rtl/b1_loc_gen_lfsr.sv
// B1I G1/G2 Gold-code generator truncated to CODE_LEN chips, with tap latch and chip counter.
// Outputs are the code/chip/epoch that will be held after the coming edge (look-ahead), no stall.
module b1_prn_lfsr
    import b1_pkg::*;
#(
    parameter int          CODE_LEN = B1_CODE_LEN,
    parameter logic [10:0] G_INIT   = B1_G_INIT
) (
    input  logic        rx_clk,
    input  logic        rx_rst_n,
    input  logic        advance,
    input  logic        load,
    input  logic [3:0]  tap1In,
    input  logic [3:0]  tap2In,
    output logic        code,
    output logic [10:0] chip,
    output logic        epoch
);

    logic [10:0] g1, g2, g1Nxt, g2Nxt, chipCnt, chipNxt;
    logic [3:0]  tap1, tap2, tap1Nxt, tap2Nxt;

    always_comb begin
        g1Nxt   = g1;
        g2Nxt   = g2;
        chipNxt = chipCnt;
        tap1Nxt = tap1;
        tap2Nxt = tap2;
        if (load) begin
            g1Nxt   = G_INIT;
            g2Nxt   = G_INIT;
            chipNxt = '0;
            tap1Nxt = tap1In;
            tap2Nxt = tap2In;
        end else if (advance) begin
            if (chipCnt == 11'(CODE_LEN - 1)) begin
                // Truncated epoch: restart both registers instead of running chip 2047.
                g1Nxt   = G_INIT;
                g2Nxt   = G_INIT;
                chipNxt = '0;
            end else begin
                g1Nxt   = {g1[9:0], ^(g1 & G1_FB_MASK)};
                g2Nxt   = {g2[9:0], ^(g2 & G2_FB_MASK)};
                chipNxt = chipCnt + 11'd1;
            end
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            g1      <= G_INIT;
            g2      <= G_INIT;
            chipCnt <= '0;
            tap1    <= 4'd1;
            tap2    <= 4'd3;
        end else begin
            g1      <= g1Nxt;
            g2      <= g2Nxt;
            chipCnt <= chipNxt;
            tap1    <= tap1Nxt;
            tap2    <= tap2Nxt;
        end
    end

    assign code  = g1Nxt[10] ^ g2Tap(g2Nxt, tap1Nxt) ^ g2Tap(g2Nxt, tap2Nxt);
    assign chip  = chipNxt;
    assign epoch = (chipNxt == 11'd0);

endmodule

// File: rtl/b1_loc_gen.sv
// B1 local replica generator: code NCO, BOC(1,1) subcarrier, E/P/L delay line and epoch pulse.
// Outputs registered, one cycle after the tick or load; free-running, no backpressure.
module b1_loc_gen
    import b1_pkg::*;
#(
    parameter int          PHASE_W  = b1_pkg::PHASE_W,
    parameter int          CODE_LEN = B1_CODE_LEN,
    parameter logic [10:0] G_INIT   = B1_G_INIT
) (
    input logic         rx_clk,
    input logic         rx_rst_n,
    b1_loc_gen_if.slave bus
);

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W:0]   phaseSum;
    logic               half, tick, advance, codeNxt, epochNxt, sop;
    logic [10:0]        chipNxt;
    dlyStage_t          stE, stP, stL;

    assign phaseSum = {1'b0, phase} + {1'b0, bus.rx_prn_fcw};
    assign tick     = bus.rx_en & phaseSum[PHASE_W] & ~bus.rx_load;
    assign advance  = tick & half;

    b1_prn_lfsr #(.CODE_LEN(CODE_LEN), .G_INIT(G_INIT)) uLfsr (
        .rx_clk   (rx_clk),
        .rx_rst_n (rx_rst_n),
        .advance  (advance),
        .load     (bus.rx_load),
        .tap1In   (bus.rx_g2_tap1),
        .tap2In   (bus.rx_g2_tap2),
        .code     (codeNxt),
        .chip     (chipNxt),
        .epoch    (epochNxt)
    );

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            phase <= '0;
            half  <= 1'b0;
            stE   <= '0;
            stP   <= '0;
            stL   <= '0;
            sop   <= 1'b0;
        end else if (bus.rx_load) begin
            phase <= '0;
            half  <= 1'b0;
            stE   <= '{early: codeNxt, epoch: 1'b1, chip: 11'd0};
            stP   <= '0;
            stL   <= '0;
            sop   <= 1'b0;
        end else begin
            sop <= 1'b0;
            if (bus.rx_en) phase <= phaseSum[PHASE_W-1:0];
            if (tick) begin
                half <= ~half;
                // Epoch starts where the wrap lands on half 0, i.e. the advance from half 1.
                stE  <= '{early: codeNxt ^ ~half, epoch: epochNxt & half, chip: chipNxt};
                stP  <= stE;
                stL  <= stP;
                sop  <= stE.epoch;
            end
        end
    end

    assign bus.tx_loc_bocE = stE.early;
    assign bus.tx_loc_bocP = stP.early;
    assign bus.tx_loc_bocL = stL.early;
    assign bus.tx_prn_sop  = sop;
    assign bus.tx_chip_idx = stP.chip;

endmodule

// File: doc/b1_loc_gen.md
# b1_loc_gen

B1 local replica generator: the transmit-side counterpart of the B1 tracking loop. It takes the code frequency control word produced by the loop and runs a 32-bit code NCO. It also runs a B1I Gold-code generator (G1/G2 11-stage LFSRs, 2046-chip epoch) and a BOC(1,1) square-wave subcarrier. From these it drives the early/prompt/late BOC replica bits and the prompt epoch pulse that the tracking loop's correlators consume.

## Interface
Parameters:
- PHASE_W, 32, code NCO accumulator width.
- CODE_LEN, 2046, chips per epoch.
- G_INIT, 11'b01010101010, initial state for G1 and G2.

Ports:
- rx_clk, in, 1, sole clock.
- rx_rst_n, in, 1, reset, asynchronous, active-low.
- rx_en, in, 1, NCO advance enable; low freezes all state.
- rx_load, in, 1, one-cycle pulse that restarts the code at chip 0, half 0 and latches the tap selectors.
- rx_g2_tap1, in, 4, first G2 output tap (1..11) used to form the PRN phase.
- rx_g2_tap2, in, 4, second G2 output tap (1..11).
- rx_prn_fcw, in, PHASE_W, code NCO increment; one half-chip = 2^PHASE_W phase.
- tx_loc_bocE, out, 1, early replica; 1 = negate the sample.
- tx_loc_bocP, out, 1, prompt replica.
- tx_loc_bocL, out, 1, late replica.
- tx_prn_sop, out, 1, one-cycle pulse marking the start of the prompt epoch.
- tx_chip_idx, out, 11, prompt chip index, 0..CODE_LEN-1.

## Operation
- **NCO.** Each enabled cycle: {carry, phase} = phase + rx_prn_fcw. A carry is a half-chip tick.
- **Half-chip state.** The half bit toggles on every tick.
- **Chip advance.** On a tick where the half bit goes 1→0, advance the chip:
  - Shift G1 with feedback taps 1,7,8,9,10,11.
  - Shift G2 with feedback taps 1,2,3,4,5,8,9,11.
  - Increment the chip counter.
- **Epoch wrap.** At chip CODE_LEN-1 the advance wraps the counter to 0 and reloads G1 = G2 = G_INIT. The LFSRs are truncated to 2046 chips, not run for 2047.
- **Code bit.** code = G1[11] ^ G2[tap1] ^ G2[tap2].
- **Early replica.** early = code ^ half (BOC(1,1) subcarrier, half 0 → +1).
- **Delay line.** A 2-deep shift register is clocked only on ticks. It holds {early bit, epoch flag, chip index}.
  - P = E delayed one half-chip.
  - L = E delayed two half-chips.
  - E–L spacing is one chip.
- **Epoch flag.** Set when the early replica is at chip 0, half 0.
- **tx_prn_sop.** Pulses for the single cycle in which the prompt stage takes a set epoch flag.
- **tx_chip_idx.** Follows the prompt stage.
- **rx_load.**
  - Clears phase, half, chip counter and delay line.
  - Sets G1/G2 = G_INIT and latches the taps.
  - E then presents chip 0, half 0.
  - sop fires one half-chip tick later, when P reaches chip 0.
- **Priority.** rx_load overrides any tick in the same cycle; the rx_en state does not matter.
- **rx_en low.** Phase, LFSRs, counters and outputs hold.
- **rx_prn_fcw change.** Takes effect on the next accumulation.
- **rx_prn_fcw = 0.** Outputs frozen.
- **Valid fcw range.** rx_prn_fcw must be below 2^(PHASE_W-1), i.e. at most one tick per two clocks. The block does not check this; larger values violate it.
- **Invalid taps.** Tap values 0 or >11 select G2[1].

## Timing
- **Reset values.**
  - phase = 0, half = 0, chip = 0, G1 = G2 = G_INIT, taps = 1/3 (PRN1).
  - tx_loc_bocE/P/L = 0, tx_prn_sop = 0, tx_chip_idx = 0.
- **Registered outputs.** All outputs are registered.
- **Tick to output.** A tick occurring in cycle n updates E/P/L/sop/chip_idx at the rx_clk edge ending cycle n (1-cycle latency).
- **Load to output.** An rx_load pulse in cycle n gives E = G_INIT code bit ^ 0 after edge n.
- **sop width.** Exactly one cycle, regardless of fcw.
- **Epoch period.** 2×CODE_LEN ticks.
- **Reset mid-run.** Asynchronously forces reset values. The first tick after release needs ≥ ceil(2^PHASE_W / fcw) cycles.

## Structure
- **Package b1_pkg.**
  - B1_CODE_LEN = 2046, B1_G_INIT, G1/G2 feedback tap masks, PHASE_W.
  - Function prn_taps(prn) → {tap1, tap2} for the upper-level channel controller.
- **Sub-module b1_prn_lfsr.**
  - Contains G1/G2, the tap mux and the chip counter.
  - Inputs: advance, load.
  - Outputs: code, chip, epoch.
- **Top level.** Holds the NCO, half bit, delay line and output registers.

## Test plan
- **Reset.** rx_rst_n low with fcw = 2^30, en = 1 → all outputs 0. After release: first tick at cycle 4, E changes every 4 cycles, P = E delayed 4 cycles, L = E delayed 8 cycles.
- **Code sequence.** Load with taps 1/3, fcw = 2^30 → first 32 prompt chips (sampled at half 0) match the B1I PRN1 golden model. The subcarrier inverts every second half-chip.
- **Epoch.** fcw = 2^30 → tx_prn_sop pulses every 16368 cycles, 1 cycle wide. tx_chip_idx is 0 at sop and 2045 just before. The LFSR sequence repeats identically after the wrap.
- **Load mid-epoch.** rx_load at chip 700, coincident with a tick → load wins. E = chip 0 half 0; sop appears exactly one tick later.
- **Freeze.** rx_en = 0 for 50 cycles, then fcw = 0 for 50 cycles → outputs and tx_chip_idx constant. Resuming continues the sequence with no skipped or duplicated chip.
- **fcw step.** fcw steps 2^30 → 2^29 mid-chip → tick spacing changes from 4 to 8 cycles starting from the next accumulation. Phase is continuous.
